// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter and the data-side load unit.
package imem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int IDX_W_DEF = 12;
  localparam int INSTR_W   = 32;

  // Byte address must be word aligned and fall inside the 2**idx_w word ROM.
  function automatic logic addr_err(input logic [INSTR_W-1:0] addr, input int idx_w);
    return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != '0);
  endfunction

endpackage

// File: rtl/imem_arb_if.sv
// Request/response bundle between the fetch and data requesters and the imem arbiter.
interface imem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          f_req_valid;
  logic          f_req_ready;
  logic [AW-1:0] f_addr;
  logic          f_rsp_valid;
  logic [DW-1:0] f_rsp_data;
  logic          f_rsp_err;

  logic          d_req_valid;
  logic          d_req_ready;
  logic [AW-1:0] d_addr;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic          d_rsp_err;

  modport master (
    output f_req_valid, f_addr, d_req_valid, d_addr,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
  );

  modport slave (
    input  f_req_valid, f_addr, d_req_valid, d_addr,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
  );
endinterface

// File: rtl/imem_addr_chk.sv
// Byte address to ROM word index, plus the misaligned/out-of-range flag.
module imem_addr_chk
  import imem_pkg::*;
#(
  parameter int AW    = 32,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [AW-1:0]    addr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             err_o
);

  assign idx_o = addr_i[IDX_W+1:2];
  assign err_o = addr_err(32'(addr_i), IDX_W);

endmodule

// File: rtl/imem_arb.sv
// Fetch-priority arbiter in front of the single-port instruction ROM, with a
// starvation counter that forces a data-side grant after STARVE_MAX lost cycles.
module imem_arb
  import imem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_arb_if.slave        bus,
  output logic             mem_en,
  output logic [IDX_W-1:0] mem_idx,
  input  logic [DW-1:0]    mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [IDX_W-1:0] f_idx, d_idx;
  logic             f_err, d_err;
  logic             grant_f, grant_d;
  owner_e           owner_q, owner_d;
  logic             err_q, err_d;
  logic [3:0]       starve_q, starve_d;

  imem_addr_chk #(.AW(AW), .IDX_W(IDX_W)) u_f_chk (
    .addr_i (bus.f_addr),
    .idx_o  (f_idx),
    .err_o  (f_err)
  );

  imem_addr_chk #(.AW(AW), .IDX_W(IDX_W)) u_d_chk (
    .addr_i (bus.d_addr),
    .idx_o  (d_idx),
    .err_o  (d_err)
  );

  always_comb begin
    grant_d = bus.d_req_valid & (~bus.f_req_valid | (starve_q == STARVE_LIM));
    grant_f = bus.f_req_valid & ~grant_d;

    // Bad addresses are accepted and answered, but never touch the ROM.
    mem_en  = (grant_f & ~f_err) | (grant_d & ~d_err);
    mem_idx = '0;
    owner_d = OWN_NONE;
    err_d   = 1'b0;
    if (grant_d) begin
      mem_idx = d_idx;
      owner_d = OWN_D;
      err_d   = d_err;
    end else if (grant_f) begin
      mem_idx = f_idx;
      owner_d = OWN_F;
      err_d   = f_err;
    end

    starve_d = '0;
    if (bus.d_req_valid & ~grant_d) begin
      starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
    end
  end

  assign bus.f_req_ready = grant_f;
  assign bus.d_req_ready = grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  // ROM data lands one cycle after the grant; route it to whoever owned that grant.
  assign bus.f_rsp_valid = (owner_q == OWN_F);
  assign bus.f_rsp_err   = (owner_q == OWN_F) & err_q;
  assign bus.f_rsp_data  = ((owner_q == OWN_F) && !err_q) ? mem_rdata : '0;

  assign bus.d_rsp_valid = (owner_q == OWN_D);
  assign bus.d_rsp_err   = (owner_q == OWN_D) & err_q;
  assign bus.d_rsp_data  = ((owner_q == OWN_D) && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arb.sv
// Directed bench for imem_arb: per-cycle vector table plus starvation and reset sequences.
module tb_imem_arb;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en;
  logic [11:0] mem_idx;
  logic [31:0] mem_rdata = '0;
  logic [31:0] rom [4096];

  int n_chk  = 0;
  int n_pass = 0;

  imem_arb_if #(.AW(32), .DW(32)) bus ();

  imem_arb #(.AW(32), .DW(32), .IDX_W(12), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_idx   (mem_idx),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= rom[mem_idx];
  end

  typedef struct {
    logic        fv;
    logic [31:0] fa;
    logic        dv;
    logic [31:0] da;
    logic        efr, edr, een;
    logic [11:0] eidx;
    logic        efv, efe;
    logic [31:0] efd;
    logic        edv, ede;
    logic [31:0] edd;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic fv, input logic [31:0] fa, input logic dv,
                              input logic [31:0] da, input logic efr, input logic edr,
                              input logic een, input logic [11:0] eidx,
                              input logic efv, input logic efe, input logic [31:0] efd,
                              input logic edv, input logic ede, input logic [31:0] edd);
    vec_t v;
    v.fv = fv;   v.fa = fa;   v.dv = dv;   v.da = da;
    v.efr = efr; v.edr = edr; v.een = een; v.eidx = eidx;
    v.efv = efv; v.efe = efe; v.efd = efd;
    v.edv = edv; v.ede = ede; v.edd = edd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic fv, input logic [31:0] fa, input logic dv, input logic [31:0] da);
    bus.f_req_valid = fv;
    bus.f_addr      = fa;
    bus.d_req_valid = dv;
    bus.d_addr      = da;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 32'hC0DE_0000 | i;
    rom[4]    = 32'h0010_0093;
    rom[4095] = 32'hDEAD_BEEF;

    //        fv  fa            dv  da            efr edr een idx     efv efe efd            edv ede edd
    tbl[0]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 12'h000, 0, 0, 32'h0,         0, 0, 32'h0);
    tbl[1]  = mk(1, 32'h10,       0, 32'h0,        1, 0, 1, 12'h004, 0, 0, 32'h0,         0, 0, 32'h0);
    tbl[2]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 12'h000, 1, 0, 32'h0010_0093, 0, 0, 32'h0);
    tbl[3]  = mk(1, 32'h6,        0, 32'h0,        1, 0, 0, 12'h001, 0, 0, 32'h0,         0, 0, 32'h0);
    tbl[4]  = mk(0, 32'h0,        1, 32'h4000,     0, 1, 0, 12'h000, 1, 1, 32'h0,         0, 0, 32'h0);
    tbl[5]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 12'h000, 0, 0, 32'h0,         1, 1, 32'h0);
    tbl[6]  = mk(0, 32'h0,        1, 32'h3FFC,     0, 1, 1, 12'hFFF, 0, 0, 32'h0,         0, 0, 32'h0);
    tbl[7]  = mk(1, 32'h8,        1, 32'h20,       1, 0, 1, 12'h002, 0, 0, 32'h0,         1, 0, 32'hDEAD_BEEF);
    tbl[8]  = mk(0, 32'h0,        1, 32'h20,       0, 1, 1, 12'h008, 1, 0, 32'hC0DE_0002, 0, 0, 32'h0);
    tbl[9]  = mk(1, 32'hC,        0, 32'h0,        1, 0, 1, 12'h003, 0, 0, 32'h0,         1, 0, 32'hC0DE_0008);
    tbl[10] = mk(0, 32'h0,        1, 32'h24,       0, 1, 1, 12'h009, 1, 0, 32'hC0DE_0003, 0, 0, 32'h0);
    tbl[11] = mk(1, 32'h3FF8,     0, 32'h0,        1, 0, 1, 12'hFFE, 0, 0, 32'h0,         1, 0, 32'hC0DE_0009);
    tbl[12] = mk(1, 32'h8000_0000, 0, 32'h0,       1, 0, 0, 12'h000, 1, 0, 32'hC0DE_0FFE, 0, 0, 32'h0);
    tbl[13] = mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 12'h000, 1, 1, 32'h0,         0, 0, 32'h0);
    tbl[14] = mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 12'h000, 0, 0, 32'h0,         0, 0, 32'h0);

    rst_n = 1'b0;
    drive(0, 32'h0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_f_rsp", {bus.f_rsp_valid, bus.f_rsp_err, bus.f_rsp_data}, 34'h0);
    chk("reset_d_rsp", {bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data}, 34'h0);
    chk("reset_starve", 64'(dut.starve_q), 64'h0);
    rst_n = 1'b1;

    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      drive(tbl[r].fv, tbl[r].fa, tbl[r].dv, tbl[r].da);
      #1;
      chk($sformatf("row%0d_ready", r), {bus.f_req_ready, bus.d_req_ready}, {tbl[r].efr, tbl[r].edr});
      chk($sformatf("row%0d_mem_en", r), 64'(mem_en), 64'(tbl[r].een));
      if (tbl[r].efr | tbl[r].edr)
        chk($sformatf("row%0d_mem_idx", r), 64'(mem_idx), 64'(tbl[r].eidx));
      chk($sformatf("row%0d_f_rsp", r), {bus.f_rsp_valid, bus.f_rsp_err, bus.f_rsp_data},
          {tbl[r].efv, tbl[r].efe, tbl[r].efd});
      chk($sformatf("row%0d_d_rsp", r), {bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data},
          {tbl[r].edv, tbl[r].ede, tbl[r].edd});
    end

    // Both requesters held for 12 cycles: D must win at cycles 4 and 9 only.
    @(negedge clk);
    drive(1, 32'h40, 1, 32'h80);
    for (int c = 0; c < 13; c++) begin
      logic d_win, d_prev;
      d_win  = (c == 4) || (c == 9);
      d_prev = (c == 5) || (c == 10);
      if (c == 12) drive(0, 32'h0, 0, 32'h0);
      #1;
      if (c < 12)
        chk($sformatf("starve_c%0d_ready", c), {bus.f_req_ready, bus.d_req_ready}, {~d_win, d_win});
      if (c > 0) begin
        chk($sformatf("starve_c%0d_f_rsp", c), {bus.f_rsp_valid, bus.f_rsp_data},
            {~d_prev, d_prev ? 32'h0 : 32'hC0DE_0010});
        chk($sformatf("starve_c%0d_d_rsp", c), {bus.d_rsp_valid, bus.d_rsp_data},
            {d_prev, d_prev ? 32'hC0DE_0020 : 32'h0});
      end
      @(negedge clk);
    end

    // One lost cycle raises the counter; a D grant clears it.
    drive(1, 32'h40, 1, 32'h3FFC);
    #1;
    chk("cnt_f_ready", {bus.f_req_ready, bus.d_req_ready}, 2'b10);
    @(negedge clk);
    drive(0, 32'h0, 1, 32'h3FFC);
    #1;
    chk("cnt_after_loss", 64'(dut.starve_q), 64'h1);
    chk("cnt_d_ready", {bus.f_req_ready, bus.d_req_ready}, 2'b01);
    chk("cnt_f_rsp", {bus.f_rsp_valid, bus.f_rsp_data}, {1'b1, 32'hC0DE_0010});
    @(negedge clk);
    drive(0, 32'h0, 0, 32'h0);
    #1;
    chk("cnt_after_grant", 64'(dut.starve_q), 64'h0);
    chk("cnt_d_rsp", {bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data}, {2'b10, 32'hDEAD_BEEF});

    // Asynchronous reset between an F grant and its response drops the response.
    @(negedge clk);
    drive(1, 32'h10, 0, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 32'h0);
    #1;
    chk("rst_mid_f_rsp", {bus.f_rsp_valid, bus.f_rsp_err, bus.f_rsp_data}, 34'h0);
    chk("rst_mid_d_rsp", {bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data}, 34'h0);
    chk("rst_mid_mem_en", 64'(mem_en), 64'h0);
    @(negedge clk);
    chk("rst_hold_f_rsp", 64'(bus.f_rsp_valid), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_f_rsp", 64'(bus.f_rsp_valid), 64'h0);
    drive(1, 32'h14, 0, 32'h0);
    #1;
    chk("post_rst_grant", {bus.f_req_ready, mem_en, mem_idx}, {2'b11, 12'h005});
    @(negedge clk);
    drive(0, 32'h0, 0, 32'h0);
    #1;
    chk("post_rst_f_rsp", {bus.f_rsp_valid, bus.f_rsp_err, bus.f_rsp_data}, {2'b10, 32'hC0DE_0005});
    chk("post_rst_d_rsp", 64'(bus.d_rsp_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
